wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the RISC-V pipeline: sits directly upstream of the register file and drives its `Rd`/`RegWrite`/`Wr_data` write port. It accepts the MEM-stage result, waits for variable-latency data-memory load responses through a valid handshake, and sign/zero-extends and aligns load data. It presents a single-cycle write pulse per retired instruction and stalls upstream while a load is outstanding.

## Interface
- `LOAD_TIMEOUT`, 16: cycles to wait for `dmem_rvalid` before aborting a load. Legal range 2..255. Used only with `WB_LOAD_TIMEOUT_EN`.

- `clk`  in  1  pipeline clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mem_valid`  in  1  MEM stage presents an instruction this cycle.
- `mem_Rd`  in  5  destination register.
- `mem_RegWrite`  in  1  instruction writes `mem_Rd`.
- `mem_MemtoReg`  in  1  1 = load, result comes from data memory.
- `mem_ALU_result`  in  32  ALU result (non-load) or load address (load).
- `mem_funct3`  in  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- `dmem_rvalid`  in  1  load data valid.
- `dmem_rdata`  in  32  raw little-endian word from data memory.
- `Rd`  out  5  register-file write address.
- `RegWrite`  out  1  register-file write enable, one-cycle pulse.
- `Wr_data`  out  32  register-file write data.
- `wb_stall`  out  1  upstream must hold the MEM instruction.
- `load_timeout`  out  1  one-cycle pulse: load aborted (always 0 without `WB_LOAD_TIMEOUT_EN`).

## Operation
- States: IDLE, LOAD_WAIT. Internal: captured `Rd`, `RegWrite`, `funct3`, `addr[1:0]`; 8-bit wait counter.
- Reset (async): state IDLE, counter 0. `Rd`=0, `RegWrite`=0, `Wr_data`=0, `wb_stall`=0, `load_timeout`=0.
- IDLE, `mem_valid`=1, `mem_MemtoReg`=0: next edge drives `Rd`=`mem_Rd`, `Wr_data`=`mem_ALU_result`, `RegWrite`=`mem_RegWrite && mem_Rd!=0`. Stay IDLE.
- IDLE, `mem_valid`=1, `mem_MemtoReg`=1: capture fields. Counter goes to 0. Go to LOAD_WAIT. `RegWrite` stays 0.
- IDLE, `mem_valid`=0: `RegWrite`=0. `dmem_rvalid` is ignored in IDLE.
- LOAD_WAIT with `dmem_rvalid`=1: next edge writes the formatted data to the captured `Rd`, with `RegWrite`=`captured RegWrite && Rd!=0`. Go to IDLE.
- LOAD_WAIT with `dmem_rvalid`=0: counter increments and `RegWrite`=0. `mem_valid` is ignored, because upstream is stalled.
- Load formatting, using the byte lane `addr[1:0]` and the halfword lane `addr[1]` (`addr[0]` is ignored for halfwords):
  - LB: sign-extend the selected byte.
  - LBU: zero-extend the selected byte.
  - LH: sign-extend the selected halfword.
  - LHU: zero-extend the selected halfword.
  - LW: full word, `addr` ignored.
  - Any other `funct3`: treated as LW.
- `Rd`/`Wr_data` hold their last value when `RegWrite`=0.
- Writes to x0 never assert `RegWrite`.

## Timing
- Non-load latency: 1 cycle. Values are sampled at posedge N, the outputs are valid after N, and the register file writes on the negedge within cycle N+1.
- Load latency: 1 cycle after the edge that samples `dmem_rvalid`=1.
- `wb_stall` is registered: it is 1 exactly while the state is LOAD_WAIT. It rises the cycle after the load is accepted and falls on the edge that leaves LOAD_WAIT.
- `dmem_rvalid` may arrive at the earliest in the first LOAD_WAIT cycle.
- `dmem_rvalid` is sampled only in LOAD_WAIT; each pulse retires exactly one load.
- Reset asserted mid-load: immediately IDLE, stall cleared, no write. A late `dmem_rvalid` after reset is ignored.

## Configuration
- `WB_LOAD_TIMEOUT_EN` defined:
  - Abort condition: in LOAD_WAIT, the counter equals `LOAD_TIMEOUT-1` and `dmem_rvalid`=0 at that edge.
  - Abort response: go to IDLE, pulse `load_timeout` for one cycle, no register write.
  - If `dmem_rvalid` arrives on the timeout edge, the data is written and there is no timeout.
- `WB_LOAD_TIMEOUT_EN` undefined: LOAD_WAIT waits indefinitely, `load_timeout` is tied to 0, and the counter is not instantiated.

## Test plan
- Reset mid-LOAD_WAIT -> `wb_stall`, `RegWrite`, `Rd`, `Wr_data` all 0 immediately; a following `dmem_rvalid` produces no write.
- ALU op `mem_Rd`=5, result 0x12345678, then `mem_Rd`=0 -> one `RegWrite` pulse to x5 with 0x12345678; no pulse for x0.
- LB, `addr`=2'b11, `dmem_rdata`=0x80FF7F01, `dmem_rvalid` 3 cycles later -> `wb_stall` high 3 cycles, then `Wr_data`=0xFFFFFF80; LBU at the same address -> 0x00000080.
- LH, `addr[1]`=1, `dmem_rdata`=0x8001ABCD -> 0xFFFF8001; LHU -> 0x00008001; LW -> 0x8001ABCD.
- With `WB_LOAD_TIMEOUT_EN`, `LOAD_TIMEOUT`=4, no `dmem_rvalid` -> `wb_stall` high 4 cycles, `load_timeout` pulses once, no write; repeat with `dmem_rvalid` on the 4th cycle -> data written, `load_timeout` stays 0.
- Back-to-back ALU, load, ALU with `dmem_rvalid` 1 cycle after acceptance -> three writes in order; the second ALU op is held by `wb_stall` and retires the cycle after the load.

Source files
------------

// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- RISC-V writeback stage.
//
// Drives the register-file write port from the MEM-stage result. Loads park
// the stage in LOAD_WAIT until the data memory answers; the returned word is
// then aligned and sign/zero-extended according to the captured funct3 and
// address lane.
//
// Optional feature macro: WB_LOAD_TIMEOUT_EN
//   defined   -> a load with no response after LOAD_TIMEOUT wait cycles is
//                aborted: no register write, one-cycle load_timeout pulse.
//   undefined -> LOAD_WAIT waits forever, load_timeout is tied low and the
//                wait counter does not exist.
//
// Parameters
//   LOAD_TIMEOUT   wait cycles before a load is aborted (2..255)
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   mem_valid         MEM stage presents an instruction
//   mem_Rd            destination register
//   mem_RegWrite      instruction writes mem_Rd
//   mem_MemtoReg      1 = load
//   mem_ALU_result    ALU result, or load address for loads
//   mem_funct3        load size/sign (LB/LH/LW/LBU/LHU)
//   dmem_rvalid       load data valid
//   dmem_rdata        raw little-endian data word
//   Rd, RegWrite,     register-file write port; RegWrite is a one-cycle
//   Wr_data           pulse, Rd/Wr_data hold when no write happens
//   wb_stall          upstream must hold its instruction
//   load_timeout      one-cycle pulse when a load is aborted
//
// Handshakes:
//   MEM -> WB : an instruction is taken on any posedge with mem_valid=1 and
//               wb_stall=0. While wb_stall=1 the stage ignores mem_valid and
//               upstream keeps presenting the same instruction.
//   DMEM -> WB: dmem_rvalid is a valid-only pulse (no ready). It is looked at
//               only in LOAD_WAIT, and each sampled pulse retires one load.
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int unsigned LOAD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic [4:0]  mem_Rd,
  input  logic        mem_RegWrite,
  input  logic        mem_MemtoReg,
  input  logic [31:0] mem_ALU_result,
  input  logic [2:0]  mem_funct3,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  Rd,
  output logic        RegWrite,
  output logic [31:0] Wr_data,
  output logic        wb_stall,
  output logic        load_timeout
);

  if (LOAD_TIMEOUT < 2 || LOAD_TIMEOUT > 255) begin : g_param_check
    $error("wb_stage: LOAD_TIMEOUT must be in 2..255");
  end

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } wb_state_e;

  wb_state_e   state_q;
  logic [4:0]  cap_rd_q;
  logic        cap_rw_q;
  logic [2:0]  cap_f3_q;
  logic [1:0]  cap_addr_q;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(LOAD_TIMEOUT - 1);
  logic [7:0] wait_cnt_q;
`endif

  // Load data formatting from the captured funct3 / address lane.
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data_d;

  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (cap_addr_q)
      2'b00:   byte_sel = dmem_rdata[7:0];
      2'b01:   byte_sel = dmem_rdata[15:8];
      2'b10:   byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    // addr[0] plays no part in halfword selection.
    half_sel = cap_addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (cap_f3_q)
      3'b000:  load_data_d = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data_d = {24'd0, byte_sel};
      3'b001:  load_data_d = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data_d = {16'd0, half_sel};
      default: load_data_d = dmem_rdata;  // LW and unused encodings
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cap_rd_q   <= 5'd0;
      cap_rw_q   <= 1'b0;
      cap_f3_q   <= 3'd0;
      cap_addr_q <= 2'd0;
      Rd         <= 5'd0;
      RegWrite   <= 1'b0;
      Wr_data    <= 32'd0;
      wb_stall   <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      wait_cnt_q   <= 8'd0;
      load_timeout <= 1'b0;
`endif
    end else begin
      RegWrite <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
      load_timeout <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (mem_valid) begin
            if (mem_MemtoReg) begin
              cap_rd_q   <= mem_Rd;
              cap_rw_q   <= mem_RegWrite;
              cap_f3_q   <= mem_funct3;
              cap_addr_q <= mem_ALU_result[1:0];
              state_q    <= ST_LOAD_WAIT;
              wb_stall   <= 1'b1;
`ifdef WB_LOAD_TIMEOUT_EN
              wait_cnt_q <= 8'd0;
`endif
            end else if (mem_RegWrite && (mem_Rd != 5'd0)) begin
              // Port values only move on a real write; otherwise they hold.
              Rd       <= mem_Rd;
              Wr_data  <= mem_ALU_result;
              RegWrite <= 1'b1;
            end
          end
        end
        ST_LOAD_WAIT: begin
          if (dmem_rvalid) begin
            state_q  <= ST_IDLE;
            wb_stall <= 1'b0;
            if (cap_rw_q && (cap_rd_q != 5'd0)) begin
              Rd       <= cap_rd_q;
              Wr_data  <= load_data_d;
              RegWrite <= 1'b1;
            end
`ifdef WB_LOAD_TIMEOUT_EN
          end else if (wait_cnt_q == TIMEOUT_LAST) begin
            state_q      <= ST_IDLE;
            wb_stall     <= 1'b0;
            load_timeout <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
`endif
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          wb_stall <= 1'b0;
        end
      endcase
    end
  end

`ifndef WB_LOAD_TIMEOUT_EN
  assign load_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage.
//
// Observed port bundle: {wb_stall, load_timeout, RegWrite, Rd, Wr_data}.
// exp_rd / exp_data track what the write port should be holding; load
// results come from ref_load, which works on plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  localparam int unsigned TB_TIMEOUT = 4;
`ifdef WB_LOAD_TIMEOUT_EN
  localparam int MAX_DELAY = 4;
`else
  localparam int MAX_DELAY = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_Rd = '0;
  logic        mem_RegWrite = 1'b0;
  logic        mem_MemtoReg = 1'b0;
  logic [31:0] mem_ALU_result = '0;
  logic [2:0]  mem_funct3 = '0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [4:0]  Rd;
  logic        RegWrite;
  logic [31:0] Wr_data;
  logic        wb_stall;
  logic        load_timeout;

  logic [39:0] obs;
  assign obs = {wb_stall, load_timeout, RegWrite, Rd, Wr_data};

  int n_pass  = 0;
  int n_total = 0;

  logic [4:0]  exp_rd   = '0;
  logic [31:0] exp_data = '0;
  logic [36:0] exp_q[$];

  wb_stage #(.LOAD_TIMEOUT(TB_TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_valid      (mem_valid),
    .mem_Rd         (mem_Rd),
    .mem_RegWrite   (mem_RegWrite),
    .mem_MemtoReg   (mem_MemtoReg),
    .mem_ALU_result (mem_ALU_result),
    .mem_funct3     (mem_funct3),
    .dmem_rvalid    (dmem_rvalid),
    .dmem_rdata     (dmem_rdata),
    .Rd             (Rd),
    .RegWrite       (RegWrite),
    .Wr_data        (Wr_data),
    .wb_stall       (wb_stall),
    .load_timeout   (load_timeout)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running want finished");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load result from the architectural rules, as integer arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] f3,
                                           input logic [1:0] a,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * a)) & 32'h0000_00FF;
    h = (w >> (a[1] ? 16 : 0)) & 32'h0000_FFFF;
    case (f3)
      3'b000:  return (b >= 32'd128)   ? b - 32'd256   : b;
      3'b100:  return b;
      3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic alu_op(input string name, input logic [4:0] rd,
                        input logic rw, input logic [31:0] res);
    logic we;
    mem_valid = 1'b1; mem_MemtoReg = 1'b0; mem_Rd = rd;
    mem_RegWrite = rw; mem_ALU_result = res;
    mem_funct3 = 3'($urandom_range(0, 7));
    step();
    we = rw && (rd != 5'd0);
    if (we) begin exp_rd = rd; exp_data = res; end
    n_total++;
    if (obs !== {2'b00, we, exp_rd, exp_data})
      $display("FAIL %s: got %h want %h", name, obs, {2'b00, we, exp_rd, exp_data});
    else n_pass++;
    mem_valid = 1'b0;
  endtask

  // Accept a load, answer it `delay` cycles after acceptance.
  task automatic do_load(input string name, input logic [4:0] rd, input logic rw,
                         input logic [2:0] f3, input logic [1:0] a,
                         input logic [31:0] word, input logic [31:0] want,
                         input int delay);
    logic [31:0] r;
    logic we;
    r = $urandom();
    mem_valid = 1'b1; mem_MemtoReg = 1'b1; mem_Rd = rd;
    mem_RegWrite = rw; mem_funct3 = f3; mem_ALU_result = {r[31:2], a};
    step();
    // Garbage on the MEM side while stalled must be ignored.
    mem_valid = 1'($urandom_range(0, 1)); mem_MemtoReg = 1'($urandom_range(0, 1));
    mem_Rd = 5'($urandom_range(1, 31)); mem_RegWrite = 1'b1;
    mem_ALU_result = $urandom();
    n_total++;
    if (obs !== {3'b100, exp_rd, exp_data})
      $display("FAIL %s_accept: got %h want %h", name, obs, {3'b100, exp_rd, exp_data});
    else n_pass++;
    for (int i = 1; i < delay; i++) begin
      dmem_rvalid = 1'b0; dmem_rdata = $urandom();
      step();
      n_total++;
      if (obs !== {3'b100, exp_rd, exp_data})
        $display("FAIL %s_wait%0d: got %h want %h", name, i, obs, {3'b100, exp_rd, exp_data});
      else n_pass++;
    end
    dmem_rvalid = 1'b1; dmem_rdata = word;
    step();
    we = rw && (rd != 5'd0);
    if (we) begin exp_rd = rd; exp_data = want; end
    n_total++;
    if (obs !== {2'b00, we, exp_rd, exp_data})
      $display("FAIL %s_retire: got %h want %h", name, obs, {2'b00, we, exp_rd, exp_data});
    else n_pass++;
    dmem_rvalid = 1'b0; mem_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    n_total++;
    if (obs !== 40'h0) $display("FAIL reset_hold: got %h want %h", obs, 40'h0);
    else n_pass++;
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;  // stray pulse in IDLE
    step();
    n_total++;
    if (obs !== 40'h0) $display("FAIL reset_idle_rvalid: got %h want %h", obs, 40'h0);
    else n_pass++;
    dmem_rvalid = 1'b0;
    step();
    n_total++;
    if (obs !== 40'h0) $display("FAIL reset_idle: got %h want %h", obs, 40'h0);
    else n_pass++;
  endtask

  task automatic test_alu();
    alu_op("alu_x5", 5'd5, 1'b1, 32'h1234_5678);
    alu_op("alu_x0", 5'd0, 1'b1, 32'hDEAD_BEEF);
    alu_op("alu_nowrite", 5'd12, 1'b0, 32'hCAFE_F00D);
    alu_op("alu_x31", 5'd31, 1'b1, 32'h0BAD_F00D);
    step();
    n_total++;
    if (obs !== {3'b000, exp_rd, exp_data})
      $display("FAIL alu_idle: got %h want %h", obs, {3'b000, exp_rd, exp_data});
    else n_pass++;
  endtask

  task automatic test_load_format();
    do_load("lb",   5'd10, 1'b1, 3'b000, 2'b11, 32'h80FF_7F01, 32'hFFFF_FF80, 3);
    do_load("lbu",  5'd11, 1'b1, 3'b100, 2'b11, 32'h80FF_7F01, 32'h0000_0080, 2);
    do_load("lb0",  5'd11, 1'b1, 3'b000, 2'b00, 32'h80FF_7F01, 32'h0000_0001, 1);
    do_load("lh",   5'd12, 1'b1, 3'b001, 2'b10, 32'h8001_ABCD, 32'hFFFF_8001, 1);
    do_load("lhu",  5'd13, 1'b1, 3'b101, 2'b11, 32'h8001_ABCD, 32'h0000_8001, 2);
    do_load("lh0",  5'd13, 1'b1, 3'b001, 2'b01, 32'h8001_ABCD, 32'hFFFF_ABCD, 1);
    do_load("lw",   5'd14, 1'b1, 3'b010, 2'b10, 32'h8001_ABCD, 32'h8001_ABCD, 1);
    do_load("lw011",5'd15, 1'b1, 3'b011, 2'b01, 32'h1357_9BDF, 32'h1357_9BDF, 2);
    do_load("ld_x0",5'd0,  1'b1, 3'b010, 2'b00, 32'hAAAA_5555, 32'hAAAA_5555, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [4:0]  rd;
      logic        rw;
      logic [2:0]  f3;
      logic [1:0]  a;
      logic [31:0] w;
      rd = 5'($urandom_range(0, 31));
      rw = ($urandom_range(0, 3) != 0);
      f3 = 3'($urandom_range(0, 7));
      a  = 2'($urandom_range(0, 3));
      w  = $urandom();
      if ($urandom_range(0, 2) == 0) alu_op("rnd_alu", rd, rw, w);
      else do_load("rnd_ld", rd, rw, f3, a, w, ref_load(f3, a, w),
                   $urandom_range(1, MAX_DELAY));
    end
  endtask

  task automatic test_back_to_back();
    logic [36:0] got, want;
    exp_q.push_back({5'd3, 32'hA0A0_0003});
    exp_q.push_back({5'd7, 32'hFFFF_FFC3});
    exp_q.push_back({5'd9, 32'hB0B0_0009});
    // ALU A
    mem_valid = 1'b1; mem_MemtoReg = 1'b0; mem_Rd = 5'd3;
    mem_RegWrite = 1'b1; mem_ALU_result = 32'hA0A0_0003;
    step();
    want = exp_q.pop_front(); got = {Rd, Wr_data};
    n_total++;
    if ({RegWrite, wb_stall, got} !== {2'b10, want})
      $display("FAIL b2b_alu_a: got %b/%b/%h want 1/0/%h", RegWrite, wb_stall, got, want);
    else n_pass++;
    // load LB at lane 1
    mem_MemtoReg = 1'b1; mem_Rd = 5'd7; mem_funct3 = 3'b000;
    mem_ALU_result = 32'h0000_1001;
    step();
    n_total++;
    if ({RegWrite, wb_stall} !== 2'b01)
      $display("FAIL b2b_load_accept: got %b%b want 01", RegWrite, wb_stall);
    else n_pass++;
    // ALU B presented and held while the load answers
    mem_MemtoReg = 1'b0; mem_Rd = 5'd9; mem_ALU_result = 32'hB0B0_0009;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1122_C344;
    step();
    dmem_rvalid = 1'b0;
    want = exp_q.pop_front(); got = {Rd, Wr_data};
    n_total++;
    if ({RegWrite, wb_stall, got} !== {2'b10, want})
      $display("FAIL b2b_load: got %b/%b/%h want 1/0/%h", RegWrite, wb_stall, got, want);
    else n_pass++;
    step();
    mem_valid = 1'b0;
    want = exp_q.pop_front(); got = {Rd, Wr_data};
    n_total++;
    if ({RegWrite, wb_stall, got} !== {2'b10, want})
      $display("FAIL b2b_alu_b: got %b/%b/%h want 1/0/%h", RegWrite, wb_stall, got, want);
    else n_pass++;
    exp_rd = 5'd9; exp_data = 32'hB0B0_0009;
    step();
    n_total++;
    if (obs !== {3'b000, exp_rd, exp_data})
      $display("FAIL b2b_drain: got %h want %h", obs, {3'b000, exp_rd, exp_data});
    else n_pass++;
  endtask

`ifdef WB_LOAD_TIMEOUT_EN
  task automatic test_timeout();
    mem_valid = 1'b1; mem_MemtoReg = 1'b1; mem_Rd = 5'd6;
    mem_RegWrite = 1'b1; mem_funct3 = 3'b010; mem_ALU_result = 32'h40;
    step();
    mem_valid = 1'b0;
    for (int i = 1; i < int'(TB_TIMEOUT); i++) begin
      step();
      n_total++;
      if (obs !== {3'b100, exp_rd, exp_data})
        $display("FAIL to_wait%0d: got %h want %h", i, obs, {3'b100, exp_rd, exp_data});
      else n_pass++;
    end
    step();
    n_total++;
    if (obs !== {3'b010, exp_rd, exp_data})
      $display("FAIL to_abort: got %h want %h", obs, {3'b010, exp_rd, exp_data});
    else n_pass++;
    step();
    n_total++;
    if (obs !== {3'b000, exp_rd, exp_data})
      $display("FAIL to_after: got %h want %h", obs, {3'b000, exp_rd, exp_data});
    else n_pass++;
    // Answer on the timeout edge: data wins.
    do_load("to_edge", 5'd6, 1'b1, 3'b010, 2'b00, 32'h7777_1234, 32'h7777_1234,
            int'(TB_TIMEOUT));
  endtask
`else
  task automatic test_long_wait();
    do_load("long_wait", 5'd21, 1'b1, 3'b101, 2'b00, 32'h0000_F00F, 32'h0000_F00F, 24);
  endtask
`endif

  task automatic test_reset_mid_load();
    alu_op("pre_rst", 5'd17, 1'b1, 32'h55AA_55AA);
    mem_valid = 1'b1; mem_MemtoReg = 1'b1; mem_Rd = 5'd18;
    mem_RegWrite = 1'b1; mem_funct3 = 3'b010; mem_ALU_result = 32'h80;
    step();
    mem_valid = 1'b0;
    step();
    n_total++;
    if (obs !== {3'b100, exp_rd, exp_data})
      $display("FAIL rst_pre: got %h want %h", obs, {3'b100, exp_rd, exp_data});
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (obs !== 40'h0) $display("FAIL rst_async: got %h want %h", obs, 40'h0);
    else n_pass++;
    step();
    rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_ABCD;  // late response
    step();
    dmem_rvalid = 1'b0;
    exp_rd = '0; exp_data = '0;
    n_total++;
    if (obs !== 40'h0) $display("FAIL rst_late_rvalid: got %h want %h", obs, 40'h0);
    else n_pass++;
  endtask

  // ---------------- main ----------------
  initial begin
    test_reset();
    test_alu();
    test_load_format();
    test_back_to_back();
`ifdef WB_LOAD_TIMEOUT_EN
    test_timeout();
`else
    test_long_wait();
`endif
    test_random();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
